// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the instruction-fetch front end.
// Holds the fetch FSM encoding, buffer depth and the {pc, inst} entry layout.
package fetch_unit_pkg;

  localparam int INST_ADDR_BUS   = 32;
  localparam int INST_BUS        = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int CNT_W           = 2;

  typedef enum logic {
    FETCH_STATE_RUN  = 1'b0,
    FETCH_STATE_KILL = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_BUS-1:0] next_word(input logic [INST_ADDR_BUS-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, inst} FIFO between instruction memory and decode.
// The head entry lives in its own register so decode sees registered outputs.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      push_entry,
  output logic [CNT_W-1:0]  count,
  output fetch_entry_t      head
);

  fetch_entry_t     tail;
  logic             pop_ok;
  logic             push_ok;
  logic [CNT_W-1:0] slot;

  // A full buffer only accepts a push when the head leaves on the same edge.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != CNT_W'(FETCH_BUF_DEPTH)) || pop_ok);
    slot    = count - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (pop_ok) begin
        head <= tail;
      end
      if (push_ok) begin
        if (slot == '0) begin
          head <= push_entry;
        end else begin
          tail <= push_entry;
        end
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word fetches, buffers {pc, inst} for decode,
// and squashes wrong-path fetches when decode redirects on the head instruction.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                       BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     o_memReq,
  output logic [INST_ADDR_BUS-1:0] o_memAddr,
  input  logic                     i_memAck,
  input  logic [INST_BUS-1:0]      i_memData,
  input  logic                     i_stall,
  input  logic                     i_takeBranch,
  input  logic [INST_ADDR_BUS-1:0] i_jpc,
  output logic                     o_valid,
  output logic [INST_ADDR_BUS-1:0] o_pc,
  output logic [INST_BUS-1:0]      o_inst
);

  fetch_state_e             state;
  logic [INST_ADDR_BUS-1:0] next_pc;
  logic                     pop;
  logic                     redirect;
  logic                     hit;
  logic                     push;
  logic                     room;
  logic [CNT_W-1:0]         count;
  logic [CNT_W:0]           count_after;
  fetch_entry_t             head;
  fetch_entry_t             push_entry;

  // Data returning in KILL or on a redirect edge belongs to the wrong path.
  always_comb begin
    pop         = o_valid && !i_stall;
    redirect    = pop && i_takeBranch;
    hit         = o_memReq && i_memAck;
    push        = hit && (state == FETCH_STATE_RUN) && !redirect;
    count_after = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    room        = int'(count_after) < BUF_DEPTH;
    push_entry  = '{pc: o_memAddr, inst: i_memData};
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .count      (count),
    .head       (head)
  );

  assign o_valid = (count != '0);
  assign o_pc    = head.pc;
  assign o_inst  = head.inst;

  // A request is only issued when its data is guaranteed a free buffer slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH_STATE_RUN;
      o_memReq  <= 1'b0;
      o_memAddr <= '0;
      next_pc   <= RESET_PC;
    end else begin
      case (state)
        FETCH_STATE_RUN: begin
          if (redirect) begin
            if (o_memReq && !hit) begin
              state   <= FETCH_STATE_KILL;
              next_pc <= i_jpc;
            end else begin
              o_memReq  <= 1'b1;
              o_memAddr <= i_jpc;
              next_pc   <= next_word(i_jpc);
            end
          end else if ((!o_memReq || hit) && room) begin
            o_memReq  <= 1'b1;
            o_memAddr <= next_pc;
            next_pc   <= next_word(next_pc);
          end else if (hit) begin
            o_memReq <= 1'b0;
          end
        end
        FETCH_STATE_KILL: begin
          if (hit) begin
            o_memAddr <= next_pc;
            next_pc   <= next_word(next_pc);
            state     <= FETCH_STATE_RUN;
          end
        end
        default: state <= FETCH_STATE_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(count) + int'(o_memReq) <= BUF_DEPTH);
    end
  end

endmodule
